// File: rtl/proc_mem_arbiter.sv
// proc_mem_arbiter: shares one single-ported memory between the fetch (imem) and data (dmem)
// ports with a single outstanding transaction and round-robin grant between simultaneous requesters.
module proc_mem_arbiter #(
    parameter int p_addr_nbits = 32,
    parameter int p_data_nbits = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    imemreq_val,
    output logic                    imemreq_rdy,
    input  logic [p_addr_nbits-1:0] imemreq_addr,
    output logic                    imemresp_val,
    input  logic                    imemresp_rdy,
    output logic [p_data_nbits-1:0] imemresp_data,

    input  logic                    dmemreq_val,
    output logic                    dmemreq_rdy,
    input  logic                    dmemreq_type,
    input  logic [p_addr_nbits-1:0] dmemreq_addr,
    input  logic [p_data_nbits-1:0] dmemreq_wdata,
    output logic                    dmemresp_val,
    input  logic                    dmemresp_rdy,
    output logic [p_data_nbits-1:0] dmemresp_data,

    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic                    memreq_type,
    output logic [p_addr_nbits-1:0] memreq_addr,
    output logic [p_data_nbits-1:0] memreq_wdata,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [p_data_nbits-1:0] memresp_data,

    output logic [1:0]              trace_grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    own;
    logic                    last;
    logic                    grant_i;
    logic                    grant_d;
    logic                    req_type;
    logic [p_addr_nbits-1:0] req_addr;
    logic [p_data_nbits-1:0] req_wdata;
    logic [p_data_nbits-1:0] resp_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // With both ports valid the one that was not served last wins; last resets to imem so dmem goes first.
    always_comb begin
        state_next   = state;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        memreq_val   = 1'b0;
        memresp_rdy  = 1'b0;
        imemresp_val = 1'b0;
        dmemresp_val = 1'b0;
        case (state)
            IDLE: begin
                grant_i = imemreq_val && (!dmemreq_val || last);
                grant_d = dmemreq_val && (!imemreq_val || !last);
                if (grant_i || grant_d) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                memreq_val = 1'b1;
                if (memreq_rdy) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                memresp_rdy = 1'b1;
                if (memresp_val) begin
                    state_next = DELIVER;
                end
            end
            DELIVER: begin
                imemresp_val = !own;
                dmemresp_val = own;
                if (own ? dmemresp_rdy : imemresp_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured at grant so the memory sees them stable through any ISSUE stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own       <= 1'b0;
            last      <= 1'b0;
            req_type  <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            resp_buf  <= '0;
        end else begin
            if (grant_d) begin
                own       <= 1'b1;
                req_type  <= dmemreq_type;
                req_addr  <= dmemreq_addr;
                req_wdata <= dmemreq_wdata;
            end else if (grant_i) begin
                own       <= 1'b0;
                req_type  <= 1'b0;
                req_addr  <= imemreq_addr;
                req_wdata <= '0;
            end
            if (state == WAIT && memresp_val) begin
                resp_buf <= memresp_data;
            end
            if (state == DELIVER && state_next == IDLE) begin
                last <= own;
            end
        end
    end

    assign imemreq_rdy   = grant_i;
    assign dmemreq_rdy   = grant_d;
    assign memreq_type   = req_type;
    assign memreq_addr   = req_addr;
    assign memreq_wdata  = req_wdata;
    assign imemresp_data = resp_buf;
    assign dmemresp_data = resp_buf;
    assign trace_grant   = (state == IDLE) ? 2'b00 : {own, ~own};

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Scoreboard bench for proc_mem_arbiter: requester drivers, a fake SoC memory and a monitor that
// checks every cycle against a transaction-level model of arbitration and response data.
`timescale 1ns/1ps
module tb_proc_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imemreq_val = 1'b0;
    logic        imemreq_rdy;
    logic [31:0] imemreq_addr = '0;
    logic        imemresp_val;
    logic        imemresp_rdy = 1'b1;
    logic [31:0] imemresp_data;
    logic        dmemreq_val = 1'b0;
    logic        dmemreq_rdy;
    logic        dmemreq_type = 1'b0;
    logic [31:0] dmemreq_addr = '0;
    logic [31:0] dmemreq_wdata = '0;
    logic        dmemresp_val;
    logic        dmemresp_rdy = 1'b1;
    logic [31:0] dmemresp_data;
    logic        memreq_val;
    logic        memreq_rdy = 1'b1;
    logic        memreq_type;
    logic [31:0] memreq_addr;
    logic [31:0] memreq_wdata;
    logic        memresp_val = 1'b0;
    logic        memresp_rdy;
    logic [31:0] memresp_data = '0;
    logic [1:0]  trace_grant;

    proc_mem_arbiter #(.p_addr_nbits(32), .p_data_nbits(32)) dut (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
        .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy), .imemresp_data(imemresp_data),
        .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
        .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
        .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy), .dmemresp_data(dmemresp_data),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
        .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_data(memresp_data),
        .trace_grant(trace_grant)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        typ;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        ireq_q[$];
    req_t        dreq_q[$];
    logic [31:0] iexp_q[$];
    logic [31:0] dexp_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] smem [logic [31:0]];
    logic [1:0]  grant_log[$];

    int   n_cmp = 0;
    int   n_fail = 0;
    bit   rand_mode = 1'b0;
    int   mem_lat = 0;

    int   phase = 0;
    logic owner = 1'b0;
    logic last_m = 1'b0;
    logic log_next = 1'b0;
    req_t cur;

    function automatic logic [31:0] defval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : defval(a);
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected responses are computed when a request is queued: imem reads and dmem traffic use
    // disjoint address ranges, so per-port order alone fixes every expected value.
    task automatic apply_stimulus(input bit is_d, input logic typ, input logic [31:0] a,
                                  input logic [31:0] wd);
        req_t r;
        r.typ   = is_d ? typ : 1'b0;
        r.addr  = a;
        r.wdata = is_d ? wd : 32'h0;
        if (!is_d) begin
            ireq_q.push_back(r);
            iexp_q.push_back(ref_read(a));
        end else if (typ) begin
            ref_mem[a] = wd;
            dreq_q.push_back(r);
            dexp_q.push_back(wd);
        end else begin
            dreq_q.push_back(r);
            dexp_q.push_back(ref_read(a));
        end
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while ((ireq_q.size() + dreq_q.size() + iexp_q.size() + dexp_q.size()) != 0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check_output("drain_in_time", 64'(k < maxc), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_imemreq_rdy"}, imemreq_rdy, 0);
        check_output({tag, "_dmemreq_rdy"}, dmemreq_rdy, 0);
        check_output({tag, "_imemresp_val"}, imemresp_val, 0);
        check_output({tag, "_dmemresp_val"}, dmemresp_val, 0);
        check_output({tag, "_memreq_val"}, memreq_val, 0);
        check_output({tag, "_memresp_rdy"}, memresp_rdy, 0);
        check_output({tag, "_trace_grant"}, trace_grant, 0);
        check_output({tag, "_memreq_type"}, memreq_type, 0);
        check_output({tag, "_memreq_addr"}, memreq_addr, 0);
        check_output({tag, "_memreq_wdata"}, memreq_wdata, 0);
        check_output({tag, "_imemresp_data"}, imemresp_data, 0);
        check_output({tag, "_dmemresp_data"}, dmemresp_data, 0);
    endtask

    initial begin : imem_driver
        req_t r;
        forever begin
            if (ireq_q.size() == 0 || !rst) begin
                @(posedge clk); #1;
            end else begin
                r = ireq_q.pop_front();
                if (rand_mode) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                imemreq_addr = r.addr;
                imemreq_val  = 1'b1;
                forever begin
                    @(negedge clk);
                    if (!rst || imemreq_rdy) break;
                end
                if (!rst) imemreq_val = 1'b0;
                else begin @(posedge clk); #1; imemreq_val = 1'b0; end
            end
        end
    end

    initial begin : dmem_driver
        req_t r;
        forever begin
            if (dreq_q.size() == 0 || !rst) begin
                @(posedge clk); #1;
            end else begin
                r = dreq_q.pop_front();
                if (rand_mode) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                dmemreq_type  = r.typ;
                dmemreq_addr  = r.addr;
                dmemreq_wdata = r.wdata;
                dmemreq_val   = 1'b1;
                forever begin
                    @(negedge clk);
                    if (!rst || dmemreq_rdy) break;
                end
                if (!rst) dmemreq_val = 1'b0;
                else begin @(posedge clk); #1; dmemreq_val = 1'b0; end
            end
        end
    end

    initial begin : knobs
        forever begin
            @(posedge clk); #1;
            if (rand_mode) begin
                memreq_rdy   = ($urandom_range(0, 3) != 0);
                imemresp_rdy = ($urandom_range(0, 3) != 0);
                dmemresp_rdy = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Fake SoC memory: answers each accepted request after a latency and is reset with the arbiter.
    initial begin : memory_model
        logic [31:0] d;
        int          lat;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst && memreq_val && memreq_rdy) begin
                if (memreq_type) begin
                    smem[memreq_addr] = memreq_wdata;
                    d = memreq_wdata;
                end else begin
                    d = smem.exists(memreq_addr) ? smem[memreq_addr] : defval(memreq_addr);
                end
                lat     = rand_mode ? $urandom_range(0, 2) : mem_lat;
                aborted = 1'b0;
                @(posedge clk); #1;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (!rst) aborted = 1'b1;
                    @(posedge clk); #1;
                end
                if (!aborted && rst) begin
                    memresp_val  = 1'b1;
                    memresp_data = d;
                    forever begin
                        @(negedge clk);
                        if (!rst || memresp_rdy) break;
                    end
                    @(posedge clk); #1;
                    memresp_val  = 1'b0;
                    memresp_data = '0;
                end
            end
        end
    end

    // Transaction lifecycle: 0 free, 1 request to memory, 2 awaiting memory, 3 response to requester.
    initial begin : monitor
        logic gi;
        logic gd;
        logic [1:0] et;
        forever begin
            @(negedge clk);
            if (!rst) begin
                phase    = 0;
                last_m   = 1'b0;
                log_next = 1'b0;
                ireq_q.delete();
                dreq_q.delete();
                iexp_q.delete();
                dexp_q.delete();
            end else begin
                if (log_next) grant_log.push_back(trace_grant);
                et = (phase == 0) ? 2'b00 : (owner ? 2'b10 : 2'b01);
                check_output("trace_grant", trace_grant, et);
                check_output("memreq_val", memreq_val, 64'(phase == 1));
                if (phase == 1) begin
                    check_output("memreq_type", memreq_type, cur.typ);
                    check_output("memreq_addr", memreq_addr, cur.addr);
                    check_output("memreq_wdata", memreq_wdata, cur.wdata);
                end
                check_output("memresp_rdy", memresp_rdy, 64'(phase == 2));
                check_output("imemresp_val", imemresp_val, 64'(phase == 3 && !owner));
                check_output("dmemresp_val", dmemresp_val, 64'(phase == 3 && owner));
                gi = (phase == 0) && imemreq_val && (!dmemreq_val || last_m);
                gd = (phase == 0) && dmemreq_val && (!imemreq_val || !last_m);
                check_output("imemreq_rdy", imemreq_rdy, gi);
                check_output("dmemreq_rdy", dmemreq_rdy, gd);
                log_next = gi || gd;
                case (phase)
                    0: if (gi || gd) begin
                        owner = gd;
                        cur   = gd ? {dmemreq_type, dmemreq_addr, dmemreq_wdata}
                                   : {1'b0, imemreq_addr, 32'h0};
                        phase = 1;
                    end
                    1: if (memreq_rdy) phase = 2;
                    2: if (memresp_val) phase = 3;
                    default: begin
                        if (owner) begin
                            if (dexp_q.size() == 0) check_output("dmem_resp_expected", 0, 1);
                            else begin
                                check_output("dmemresp_data", dmemresp_data, dexp_q[0]);
                                if (dmemresp_rdy) begin
                                    void'(dexp_q.pop_front());
                                    phase  = 0;
                                    last_m = 1'b1;
                                end
                            end
                        end else begin
                            if (iexp_q.size() == 0) check_output("imem_resp_expected", 0, 1);
                            else begin
                                check_output("imemresp_data", imemresp_data, iexp_q[0]);
                                if (imemresp_rdy) begin
                                    void'(iexp_q.pop_front());
                                    phase  = 0;
                                    last_m = 1'b0;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    initial begin : main
        logic [1:0]  exp_order [4];
        logic [31:0] exp_word;
        int          k;
        exp_order = '{2'b10, 2'b01, 2'b10, 2'b01};

        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Both ports busy from reset: strict alternation starting with dmem.
        apply_stimulus(0, 0, 32'h0000_0000, 0);
        apply_stimulus(1, 0, 32'h0000_1000, 0);
        apply_stimulus(0, 0, 32'h0000_0004, 0);
        apply_stimulus(1, 0, 32'h0000_1004, 0);
        wait_idle(200);
        check_output("grant_log_len", 64'(grant_log.size() >= 4), 1);
        if (grant_log.size() >= 4)
            for (int i = 0; i < 4; i++) check_output("grant_order", grant_log[i], exp_order[i]);

        ref_mem[32'h0000_0100] = 32'h0020_0093;
        smem[32'h0000_0100]    = 32'h0020_0093;
        apply_stimulus(0, 0, 32'h0000_0100, 0);
        k = 0;
        do begin @(negedge clk); k++; end while (!imemreq_rdy && k < 50);
        check_output("fetch_accept", imemreq_rdy, 1);
        @(negedge clk);
        check_output("fetch_memreq_val", memreq_val, 1);
        check_output("fetch_memreq_addr", memreq_addr, 32'h0000_0100);
        @(negedge clk);
        @(negedge clk);
        check_output("fetch_resp_val", imemresp_val, 1);
        check_output("fetch_resp_data", imemresp_data, 32'h0020_0093);
        wait_idle(200);

        apply_stimulus(1, 1, 32'h0000_2000, 32'hDEAD_BEEF);
        k = 0;
        do begin @(negedge clk); k++; end while (!memreq_val && k < 50);
        check_output("store_type", memreq_type, 1);
        check_output("store_wdata", memreq_wdata, 32'hDEAD_BEEF);
        wait_idle(200);
        apply_stimulus(1, 0, 32'h0000_2000, 0);
        wait_idle(200);

        memreq_rdy   = 1'b0;
        dmemresp_rdy = 1'b0;
        exp_word     = ref_read(32'h0000_1040);
        apply_stimulus(1, 0, 32'h0000_1040, 0);
        k = 0;
        do begin @(negedge clk); k++; end while (!memreq_val && k < 50);
        for (int i = 0; i < 5; i++) begin
            check_output("bp_memreq_val", memreq_val, 1);
            check_output("bp_memreq_addr", memreq_addr, 32'h0000_1040);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        memreq_rdy = 1'b1;
        apply_stimulus(0, 0, 32'h0000_0040, 0);
        k = 0;
        do begin @(negedge clk); k++; end while (!dmemresp_val && k < 50);
        for (int i = 0; i < 3; i++) begin
            check_output("bp_dresp_val", dmemresp_val, 1);
            check_output("bp_dresp_data", dmemresp_data, exp_word);
            check_output("bp_no_grant", imemreq_rdy, 0);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        dmemresp_rdy = 1'b1;
        wait_idle(200);

        mem_lat = 4;
        apply_stimulus(0, 0, 32'h0000_0300, 0);
        k = 0;
        do begin @(negedge clk); k++; end while (!memresp_rdy && k < 50);
        check_output("rst_reached_wait", memresp_rdy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst     = 1'b1;
        mem_lat = 0;
        apply_stimulus(0, 0, 32'h0000_0200, 0);
        wait_idle(200);

        rand_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(0, 0, 32'($urandom_range(0, 63)) << 2, 0);
            apply_stimulus(1, 1'($urandom_range(0, 1)), 32'h0000_1000 + (32'($urandom_range(0, 15)) << 2),
                           32'($urandom));
        end
        wait_idle(6000);
        rand_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_mem_arbiter.md
# proc_mem_arbiter

Arbitrates the processor's instruction-fetch port (F stage) and data port (M stage) onto one shared single-ported memory interface for the Caravel build. It uses a four-state FSM with one outstanding transaction, round-robin grant, and a registered response buffer. It sits between the processor's imem/dmem val/rdy ports and the SoC-side memory port.

## Interface
- p_addr_nbits, 32, address width of all request ports
- p_data_nbits, 32, data width of all write/read data ports

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- imemreq_val  in  1  fetch request valid
- imemreq_rdy  out  1  fetch request accepted this cycle
- imemreq_addr  in  p_addr_nbits  fetch address
- imemresp_val  out  1  fetch response valid
- imemresp_rdy  in  1  fetch response accepted
- imemresp_data  out  p_data_nbits  fetched instruction
- dmemreq_val  in  1  data request valid
- dmemreq_rdy  out  1  data request accepted this cycle
- dmemreq_type  in  1  0 = read (LW), 1 = write (SW)
- dmemreq_addr  in  p_addr_nbits  data address
- dmemreq_wdata  in  p_data_nbits  store data
- dmemresp_val  out  1  data response valid
- dmemresp_rdy  in  1  data response accepted
- dmemresp_data  out  p_data_nbits  load data (write: memory's returned word)
- memreq_val  out  1  shared memory request valid
- memreq_rdy  in  1  shared memory accepts request
- memreq_type  out  1  0 read, 1 write
- memreq_addr  out  p_addr_nbits  request address
- memreq_wdata  out  p_data_nbits  request write data
- memresp_val  in  1  memory response valid
- memresp_rdy  out  1  arbiter accepts response
- memresp_data  in  p_data_nbits  response data
- trace_grant  out  2  current owner: 00 none, 01 imem, 10 dmem

## Operation
- FSM states: IDLE, ISSUE, WAIT, DELIVER. Reset state IDLE.
- Owner register `own` (0 imem, 1 dmem), last-served pointer `last` (reset 0, meaning dmem is favored first).
- IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one not equal to `last`.
  - Granted requester's `*req_rdy` = 1 combinationally in the same cycle. The other rdy = 0.
  - On grant, latch type/addr/wdata (imem: type 0, wdata 0) and `own`. Go to ISSUE.
  - No valid requester: stay in IDLE.
- ISSUE: memreq_val = 1 with buffered fields. Fields are stable while waiting. On memreq_rdy go to WAIT.
- WAIT: memresp_rdy = 1. On memresp_val latch memresp_data into the response buffer and go to DELIVER.
- DELIVER: assert resp_val of `own` only, with the buffered data. On that resp_rdy:
  - `last` <= `own`.
  - Go to IDLE.
  - Writes also complete through DELIVER.
- All req_rdy = 0 outside IDLE. memresp_rdy = 1 only in WAIT. memreq_val = 1 only in ISSUE.
- trace_grant = 00 in IDLE; otherwise {own, ~own}.

## Timing
- Reset (rst low, asynchronous): state IDLE, `last` 0, buffers 0.
  - All outputs 0: every val, every rdy, trace_grant, memreq fields, resp data.
  - Any in-flight transaction is discarded.
  - The memory side must be reset concurrently. A stale memresp is never accepted because memresp_rdy = 0 in IDLE.
- Minimum latency with memreq_rdy = 1 and 1-cycle memory:
  - request accepted cycle N
  - memreq_val cycle N+1
  - memresp_val cycle N+2
  - resp_val cycle N+3
  - next grant earliest cycle N+4 (resp_rdy high at N+3)
- Back-pressure:
  - memreq_rdy low holds ISSUE indefinitely, with fields unchanged.
  - resp_rdy low holds DELIVER, with data unchanged.
- Simultaneous requests in IDLE alternate strictly. Neither port waits more than one transaction.
- A request arriving in DELIVER is not accepted until the next IDLE cycle. Requesters hold val until rdy.
- memresp_val arriving in ISSUE is ignored (protocol violation, not supported).

## Test plan
- Reset mid-transaction: deassert rst during WAIT -> next cycle all outputs 0, state IDLE; then imem read of 0x0000_0200 completes normally.
- Single fetch: imem read 0x0000_0100, memory returns 0x0020_0093 after 1 cycle -> imemreq_rdy at N, memreq_val/addr 0x100 at N+1, imemresp_val with 0x0020_0093 at N+3, dmemresp_val never 1.
- Store: dmem write addr 0x0000_2000 data 0xDEAD_BEEF -> memreq_type 1, memreq_wdata 0xDEAD_BEEF, dmemresp_val one transaction later.
- Contention: both valid every cycle from reset for 4 transactions -> grant order dmem, imem, dmem, imem; trace_grant 10, 01, 10, 01.
- Back-pressure:
  - memreq_rdy low for 5 cycles -> memreq_val and fields held for 5 cycles.
  - dmemresp_rdy low for 3 cycles -> dmemresp_val and data held; no new grant until accepted.
